// File: rtl/lcd_fb_writer.sv
// PPU display sink: packs 2-bit pixels four per byte and writes whole frames into
// the back bank of a double-buffered framebuffer, flagging malformed lines and frames.
module lcd_fb_writer #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 144
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_pixel,
   input  logic [1:0]  lcd_color,
   input  logic        lcd_hsync,
   input  logic        lcd_vsync,
   input  logic        err_clear,
   output logic [13:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        fb_we,
   output logic        frame_sel,
   output logic        frame_ready,
   output logic        line_err,
   output logic        frame_err
);
   localparam int XW = $clog2(WIDTH + 1);
   localparam int LW = $clog2(HEIGHT + 1);
   localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
   localparam logic [LW-1:0] LINES_MAX  = LW'(HEIGHT);
   localparam logic [14:0]   LINE_BYTES = 15'(WIDTH / 4);
   localparam logic [14:0]   BANK_BYTES = 15'(WIDTH * HEIGHT / 4);

   typedef enum logic [1:0] {S_SYNC, S_LINE, S_HBLANK, S_VBLANK} state_t;

   state_t        state, state_n;
   logic          hs_q, vs_q;
   logic [XW-1:0] x, x_n;
   logic [13:0]   line_base, line_base_n;
   logic [LW-1:0] lines_done, lines_done_n;
   logic [5:0]    shift, shift_n;
   logic          advanced, advanced_n;
   logic          bank_full, bank_full_n;
   logic [13:0]   fb_addr_n;
   logic [7:0]    fb_data_n;
   logic          fb_we_n, frame_sel_n, frame_ready_n;
   logic          line_evt, frame_evt;
   logic          vs_rise, vs_fall, hs_rise, hs_fall;
   logic [14:0]   back_base, bank_end, next_base;
   logic          can_advance;

   assign vs_rise = lcd_vsync & ~vs_q;
   assign vs_fall = ~lcd_vsync & vs_q;
   assign hs_rise = lcd_hsync & ~hs_q;
   assign hs_fall = ~lcd_hsync & hs_q;

   // A line_base step is only taken if the next line still fits inside the back bank
   assign back_base   = frame_sel ? 15'd0 : BANK_BYTES;
   assign bank_end    = back_base + BANK_BYTES;
   assign next_base   = {1'b0, line_base} + LINE_BYTES;
   assign can_advance = next_base < bank_end;

   always_comb begin
      state_n       = state;
      x_n           = x;
      line_base_n   = line_base;
      lines_done_n  = lines_done;
      shift_n       = shift;
      advanced_n    = advanced;
      bank_full_n   = bank_full;
      fb_we_n       = 1'b0;
      fb_addr_n     = fb_addr;
      fb_data_n     = fb_data;
      frame_sel_n   = frame_sel;
      frame_ready_n = 1'b0;
      line_evt      = 1'b0;
      frame_evt     = 1'b0;

      if (vs_rise && state != S_SYNC) begin
         state_n = S_VBLANK;
         if (state == S_LINE && x != '0) line_evt = 1'b1;
         if (lines_done == LINES_MAX) begin
            frame_sel_n   = ~frame_sel;
            frame_ready_n = 1'b1;
         end else begin
            frame_evt = 1'b1;
         end
      end else begin
         case (state)
            S_SYNC, S_VBLANK: begin
               if (vs_fall) begin
                  state_n      = S_LINE;
                  x_n          = '0;
                  lines_done_n = '0;
                  line_base_n  = back_base[13:0];
                  shift_n      = '0;
                  advanced_n   = 1'b0;
                  bank_full_n  = 1'b0;
               end
            end
            S_LINE: begin
               // A pixel that completes the line wins over a coincident hsync rise
               if (lcd_pixel && (x == X_LAST || !hs_rise)) begin
                  shift_n = {shift[3:0], lcd_color};
                  x_n     = x + XW'(1);
                  if (x[1:0] == 2'd3 && lines_done < LINES_MAX && !bank_full) begin
                     fb_we_n   = 1'b1;
                     fb_addr_n = line_base + 14'(x >> 2);
                     fb_data_n = {shift, lcd_color};
                  end
                  if (x == X_LAST) begin
                     state_n    = S_HBLANK;
                     advanced_n = 1'b0;
                     if (lines_done == LINES_MAX) frame_evt = 1'b1;
                     else lines_done_n = lines_done + LW'(1);
                  end
               end else if (hs_rise) begin
                  line_evt   = 1'b1;
                  x_n        = '0;
                  shift_n    = '0;
                  advanced_n = 1'b1;
                  state_n    = S_HBLANK;
                  if (can_advance) line_base_n = next_base[13:0];
                  else bank_full_n = 1'b1;
               end
            end
            S_HBLANK: begin
               if (lcd_pixel) line_evt = 1'b1;
               if (hs_fall && !lcd_vsync) begin
                  state_n = S_LINE;
                  x_n     = '0;
                  shift_n = '0;
                  if (!advanced) begin
                     if (can_advance) line_base_n = next_base[13:0];
                     else bank_full_n = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Register all state and outputs; a fresh error event outranks err_clear
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_SYNC;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         x           <= '0;
         line_base   <= '0;
         lines_done  <= '0;
         shift       <= '0;
         advanced    <= 1'b0;
         bank_full   <= 1'b0;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_data     <= '0;
         frame_sel   <= 1'b0;
         frame_ready <= 1'b0;
         line_err    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_n;
         hs_q        <= lcd_hsync;
         vs_q        <= lcd_vsync;
         x           <= x_n;
         line_base   <= line_base_n;
         lines_done  <= lines_done_n;
         shift       <= shift_n;
         advanced    <= advanced_n;
         bank_full   <= bank_full_n;
         fb_we       <= fb_we_n;
         fb_addr     <= fb_addr_n;
         fb_data     <= fb_data_n;
         frame_sel   <= frame_sel_n;
         frame_ready <= frame_ready_n;
         line_err    <= (line_err & ~err_clear) | line_evt;
         frame_err   <= (frame_err & ~err_clear) | frame_evt;
      end
   end
endmodule
